// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: shadows EX/MEM/WB register usage to raise load-use stalls,
// branch flushes and EX operand forwarding selects, plus saturating event counters.
module hazard_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_memread,
    input  logic        id_regwrite,
    input  logic        id_branch,
    input  logic        ex_branch_taken,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic       ex_valid_q, ex_valid_d;
    logic [4:0] ex_rs1_q, ex_rs1_d;
    logic [4:0] ex_rs2_q, ex_rs2_d;
    logic [4:0] ex_rd_q, ex_rd_d;
    logic       ex_memread_q, ex_memread_d;
    logic       ex_regwrite_q, ex_regwrite_d;
    logic       ex_branch_q, ex_branch_d;
    logic       mem_valid_q, mem_regwrite_q;
    logic [4:0] mem_rd_q;
    logic       wb_valid_q, wb_regwrite_q;
    logic [4:0] wb_rd_q;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    logic flush;
    logic load_use;

    assign flush    = ex_valid_q & ex_branch_q & ex_branch_taken;
    assign load_use = ex_valid_q & ex_memread_q & (ex_rd_q != 5'd0) & id_valid &
                      ((ex_rd_q == id_rs1) | (ex_rd_q == id_rs2));

    // A taken branch squashes whatever sits in ID, so a load-use stall on it is moot.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (flush) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    // MEM result is younger than WB, so it takes priority for the same register.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        logic [1:0] sel;
        sel = 2'b00;
        if (mem_valid_q && mem_regwrite_q && (mem_rd_q != 5'd0) && (mem_rd_q == rs))
            sel = 2'b10;
        else if (wb_valid_q && wb_regwrite_q && (wb_rd_q != 5'd0) && (wb_rd_q == rs))
            sel = 2'b01;
        return sel;
    endfunction

    assign fwd_a = fwd_sel(ex_rs1_q);
    assign fwd_b = fwd_sel(ex_rs2_q);

    always_comb begin
        ex_valid_d    = id_valid & ~idex_bubble;
        ex_rs1_d      = id_rs1;
        ex_rs2_d      = id_rs2;
        ex_rd_d       = id_rd;
        ex_memread_d  = id_memread & ex_valid_d;
        ex_regwrite_d = id_regwrite & ex_valid_d;
        ex_branch_d   = id_branch & ex_valid_d;
        stall_cnt_d   = stall_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        if (load_use && !flush && (stall_cnt_q != CNT_MAX))
            stall_cnt_d = stall_cnt_q + 16'd1;
        if (flush && (flush_cnt_q != CNT_MAX))
            flush_cnt_d = flush_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_q     <= 1'b0;
            ex_rs1_q       <= 5'd0;
            ex_rs2_q       <= 5'd0;
            ex_rd_q        <= 5'd0;
            ex_memread_q   <= 1'b0;
            ex_regwrite_q  <= 1'b0;
            ex_branch_q    <= 1'b0;
            mem_valid_q    <= 1'b0;
            mem_rd_q       <= 5'd0;
            mem_regwrite_q <= 1'b0;
            wb_valid_q     <= 1'b0;
            wb_rd_q        <= 5'd0;
            wb_regwrite_q  <= 1'b0;
            stall_cnt_q    <= 16'd0;
            flush_cnt_q    <= 16'd0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_rs1_q       <= ex_rs1_d;
            ex_rs2_q       <= ex_rs2_d;
            ex_rd_q        <= ex_rd_d;
            ex_memread_q   <= ex_memread_d;
            ex_regwrite_q  <= ex_regwrite_d;
            ex_branch_q    <= ex_branch_d;
            mem_valid_q    <= ex_valid_q;
            mem_rd_q       <= ex_rd_q;
            mem_regwrite_q <= ex_regwrite_q;
            wb_valid_q     <= mem_valid_q;
            wb_rd_q        <= mem_rd_q;
            wb_regwrite_q  <= mem_regwrite_q;
            stall_cnt_q    <= stall_cnt_d;
            flush_cnt_q    <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use stall, forwarding priority, x0 handling,
// flush-over-stall priority, counter saturation and asynchronous reset.
module tb_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_memread, id_regwrite, id_branch;
    logic        ex_branch_taken;
    logic        pc_write, ifid_write, ifid_flush, idex_bubble;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_passed = 0;

    hazard_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rd           (id_rd),
        .id_memread      (id_memread),
        .id_regwrite     (id_regwrite),
        .id_branch       (id_branch),
        .ex_branch_taken (ex_branch_taken),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_passed++;
        else $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    endtask

    // ctl packs {pc_write, ifid_write, ifid_flush, idex_bubble}
    task automatic check_ctl(input string tag, input logic [3:0] exp);
        check_eq(tag, 16'({pc_write, ifid_write, ifid_flush, idex_bubble}), 16'(exp));
    endtask

    // drive one ID-stage slot at the falling edge, then let combinational outputs settle
    task automatic cyc(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic mr, input logic rw,
                       input logic br, input logic tk);
        @(negedge clk);
        id_valid        = v;
        id_rs1          = rs1;
        id_rs2          = rs2;
        id_rd           = rd;
        id_memread      = mr;
        id_regwrite     = rw;
        id_branch       = br;
        ex_branch_taken = tk;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset           = 1'b1;
        id_valid        = 1'b0;
        id_rs1          = 5'd0;
        id_rs2          = 5'd0;
        id_rd           = 5'd0;
        id_memread      = 1'b0;
        id_regwrite     = 1'b0;
        id_branch       = 1'b0;
        ex_branch_taken = 1'b0;
        #2;
        check_ctl("rst_ctl", 4'b1100);
        check_eq("rst_fwd", 16'({fwd_a, fwd_b}), 16'h0);
        check_eq("rst_stall_cnt", stall_cnt, 16'd0);
        check_eq("rst_flush_cnt", flush_cnt, 16'd0);
        @(negedge clk);
        reset = 1'b0;

        // load-use: LW x2 ; ADD x4, x2, x3
        cyc(1, 5'd1, 5'd0, 5'd2, 1, 1, 0, 0);
        check_ctl("lu_lw_in_id", 4'b1100);
        cyc(1, 5'd2, 5'd3, 5'd4, 0, 1, 0, 0);
        check_ctl("lu_stall", 4'b0001);
        cyc(1, 5'd2, 5'd3, 5'd4, 0, 1, 0, 0);
        check_ctl("lu_resume", 4'b1100);
        check_eq("lu_stall_cnt", stall_cnt, 16'd1);
        idle(1);
        check_eq("lu_fwd_a_wb", 16'(fwd_a), 16'h1);
        check_eq("lu_fwd_b_none", 16'(fwd_b), 16'h0);
        idle(3);

        // back-to-back ALU: ADD x3 ; SUB x6, x4, x3 (taken asserted on a non-branch)
        cyc(1, 5'd1, 5'd1, 5'd3, 0, 1, 0, 0);
        cyc(1, 5'd4, 5'd3, 5'd6, 0, 1, 0, 1);
        check_ctl("alu_no_stall", 4'b1100);
        idle(1);
        check_eq("alu_fwd_b_mem", 16'(fwd_b), 16'h2);
        check_eq("alu_fwd_a_none", 16'(fwd_a), 16'h0);
        idle(3);

        // x0 is never forwarded nor stalled on
        cyc(1, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0);
        cyc(1, 5'd0, 5'd0, 5'd7, 0, 1, 0, 0);
        check_eq("x0_fwd_a_c1", 16'(fwd_a), 16'h0);
        idle(1);
        check_eq("x0_fwd_a_c2", 16'(fwd_a), 16'h0);
        idle(1);
        check_eq("x0_fwd_a_c3", 16'(fwd_a), 16'h0);
        idle(2);
        cyc(1, 5'd1, 5'd0, 5'd0, 1, 1, 0, 0);
        cyc(1, 5'd0, 5'd0, 5'd8, 0, 1, 0, 0);
        check_ctl("x0_lw_no_stall", 4'b1100);
        check_eq("x0_stall_cnt", stall_cnt, 16'd1);
        idle(3);

        // non-writing producer must not forward
        cyc(1, 5'd1, 5'd2, 5'd9, 0, 0, 0, 0);
        cyc(1, 5'd9, 5'd0, 5'd10, 0, 1, 0, 0);
        idle(1);
        check_eq("norw_fwd_a", 16'(fwd_a), 16'h0);
        idle(3);

        // taken branch in EX that is also a load hit by ID: flush wins
        cyc(1, 5'd9, 5'd10, 5'd11, 1, 0, 1, 0);
        cyc(1, 5'd11, 5'd0, 5'd12, 1, 1, 0, 1);
        check_ctl("br_flush_wins", 4'b1111);
        cyc(1, 5'd12, 5'd0, 5'd13, 0, 1, 0, 0);
        check_eq("br_flush_cnt", flush_cnt, 16'd1);
        check_eq("br_stall_cnt", stall_cnt, 16'd1);
        check_ctl("br_squashed_no_stall", 4'b1100);
        idle(1);
        check_eq("br_squashed_no_fwd", 16'(fwd_a), 16'h0);
        idle(3);

        // MEM beats WB for x5; WB-only source for rs2
        cyc(1, 5'd1, 5'd1, 5'd5, 0, 1, 0, 0);
        cyc(1, 5'd2, 5'd2, 5'd5, 0, 1, 0, 0);
        cyc(1, 5'd5, 5'd5, 5'd6, 0, 1, 0, 0);
        idle(1);
        check_eq("prio_fwd_a_mem", 16'(fwd_a), 16'h2);
        check_eq("prio_fwd_b_mem", 16'(fwd_b), 16'h2);
        idle(3);
        cyc(1, 5'd1, 5'd1, 5'd7, 0, 1, 0, 0);
        idle(1);
        cyc(1, 5'd1, 5'd7, 5'd8, 0, 1, 0, 0);
        idle(1);
        check_eq("wb_fwd_b", 16'(fwd_b), 16'h1);
        check_eq("wb_fwd_a_none", 16'(fwd_a), 16'h0);
        idle(3);

        // saturation: preload just below the ceiling
        force dut.stall_cnt_q = 16'hFFFE;
        #1;
        release dut.stall_cnt_q;
        #1;
        check_eq("sat_preload", stall_cnt, 16'hFFFE);
        for (int k = 0; k < 2; k++) begin
            cyc(1, 5'd1, 5'd0, 5'd2, 1, 1, 0, 0);
            cyc(1, 5'd2, 5'd0, 5'd4, 0, 1, 0, 0);
            check_ctl("sat_stall", 4'b0001);
            idle(1);
            check_eq("sat_stall_cnt", stall_cnt, 16'hFFFF);
        end
        check_eq("sat_flush_cnt", flush_cnt, 16'd1);

        // reset asserted in the middle of a stall
        cyc(1, 5'd1, 5'd0, 5'd2, 1, 1, 0, 0);
        cyc(1, 5'd2, 5'd0, 5'd4, 0, 1, 0, 0);
        check_ctl("mid_stall", 4'b0001);
        reset = 1'b1;
        #1;
        check_ctl("async_rst_ctl", 4'b1100);
        check_eq("async_rst_fwd", 16'({fwd_a, fwd_b}), 16'h0);
        check_eq("async_rst_stall_cnt", stall_cnt, 16'd0);
        check_eq("async_rst_flush_cnt", flush_cnt, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_ctl("post_rst_no_carry", 4'b1100);
        idle(1);
        check_eq("post_rst_stall_cnt", stall_cnt, 16'd0);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port id_valid  input  1  ID stage holds a real instruction.
REQ-004 SHALL have ports id_rs1, id_rs2, id_rd  input  5 each  ID-stage register fields.
REQ-005 SHALL have ports id_memread, id_regwrite, id_branch  input  1 each  ID-stage decoded control.
REQ-006 SHALL have port ex_branch_taken  input  1  branch condition resolved true in EX this cycle.
REQ-007 SHALL have ports pc_write, ifid_write  output  1 each  PC / IF-ID register load enables.
REQ-008 SHALL have ports ifid_flush, idex_bubble  output  1 each  zero IF/ID; zero ID/EX control.
REQ-009 SHALL have ports fwd_a, fwd_b  output  2 each  EX operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB.
REQ-010 SHALL have ports stall_cnt, flush_cnt  output  16 each  saturating event counters.

Function
REQ-011 SHALL keep shadow records EX {valid, rs1, rs2, rd, memread, regwrite, branch}, MEM {valid, rd, regwrite}, WB {valid, rd, regwrite}.
REQ-012 SHALL advance every edge: WB<=MEM, MEM<=EX; EX<=ID fields, or EX.valid<=0 when idex_bubble=1.
REQ-013 SHALL compute flush = EX.valid & EX.branch & ex_branch_taken, combinational.
REQ-014 SHALL compute load_use = EX.valid & EX.memread & EX.rd!=0 & id_valid & (EX.rd==id_rs1 | EX.rd==id_rs2), combinational.
REQ-015 SHALL drive on flush: ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1; load_use is ignored (flush wins).
REQ-016 SHALL drive on load_use without flush: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0.
REQ-017 SHALL drive otherwise: pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=0.
REQ-018 SHALL set fwd_a=10 when MEM.valid & MEM.regwrite & MEM.rd!=0 & MEM.rd==EX.rs1; else 01 when WB.valid & WB.regwrite & WB.rd!=0 & WB.rd==EX.rs1; else 00.
REQ-019 SHALL compute fwd_b identically against EX.rs2; MEM match takes priority over WB match.
REQ-020 SHALL never forward for rd=x0 or from invalid (bubbled/flushed) records.
REQ-021 SHALL limit a load-use stall to exactly 1 cycle: after the bubble, EX holds no load, so ID proceeds next cycle.
REQ-022 SHALL increment stall_cnt by 1 on each edge where load_use & ~flush; saturate at 16'hFFFF.
REQ-023 SHALL increment flush_cnt by 1 on each edge where flush; saturate at 16'hFFFF.
REQ-024 SHALL on a flush edge also invalidate the captured EX record (bubble) so the squashed ID instruction never forwards.
REQ-025 SHALL keep all outputs other than counters combinational from records and inputs; zero added pipeline latency.

Reset
REQ-026 SHALL on reset assertion immediately clear all records' valid bits, rs/rd fields and control bits to 0, and stall_cnt, flush_cnt to 0.
REQ-027 SHALL during and after reset (before first valid ID) output pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, fwd_a=fwd_b=00.
REQ-028 SHALL drop any in-progress stall or flush when reset asserts mid-operation; no event carries over.

Verification
REQ-029 SHALL pass: LW x2 in ID, then ADD rs1=x2 in ID next cycle -> one cycle pc_write=0, ifid_write=0, idex_bubble=1, stall_cnt=1; next cycle all enables 1; two cycles after the bubble, fwd_a=01.
REQ-030 SHALL pass: ADD x3 then SUB rs2=x3 back-to-back -> no stall; when SUB in EX, fwd_b=10.
REQ-031 SHALL pass: ADD x0 then ADD rs1=x0 -> fwd_a=00 throughout; LW x0 followed by user of x0 -> no stall.
REQ-032 SHALL pass: BEQ in EX with ex_branch_taken=1 while load_use also true -> ifid_flush=1, idex_bubble=1, pc_write=1, flush_cnt=1, stall_cnt unchanged.
REQ-033 SHALL pass: x5 written by both MEM and WB records, EX rs1=x5 -> fwd_a=10.
REQ-034 SHALL pass: force stall_cnt to FFFF via repeated load-use, one more stall -> stays FFFF; assert reset mid-stall -> all outputs return to REQ-027 values asynchronously.
